// File: rtl/mem_port_arbiter.sv
// Purpose : shares one single-ported 32-bit memory between the fetch port and the data port,
//           one outstanding transaction at a time, data first, with fetch anti-starvation.
// Latency : read req sampled at t -> mem_en/gnt at t+1 -> rvalid at t+2+MEM_LAT; write: one per 2 cycles.
// Backpr. : no stall signal; a requester holds req/addr/data until its gnt pulse, and requests
//           arriving in ISSUE or WAIT wait for the next arbitration point (IDLE or RESP).
// Ports   : clk/rst_n; fetch if_req/if_addr -> if_gnt/if_rvalid/if_rdata;
//           data d_req/d_we/d_addr/d_wdata -> d_gnt/d_rvalid/d_rdata;
//           memory mem_en/mem_we/mem_addr/mem_wdata <- mem_rdata; busy in ISSUE and WAIT.
module mem_port_arbiter #(
   parameter int MEM_LAT    = 1,
   parameter int STARVE_MAX = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic        if_gnt,
   output logic        if_rvalid,
   output logic [31:0] if_rdata,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   output logic        d_gnt,
   output logic        d_rvalid,
   output logic [31:0] d_rdata,
   output logic        mem_en,
   output logic        mem_we,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   input  logic [31:0] mem_rdata,
   output logic        busy
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

   localparam logic [2:0] WAIT_LAST  = 3'(MEM_LAT - 1);
   localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

   state_t      state, state_nxt;
   logic        owner_d, owner_d_nxt;   // 1: current transaction belongs to the data port
   logic [2:0]  wait_cnt, wait_cnt_nxt;
   logic [3:0]  starve_cnt, starve_nxt;
   logic        we_nxt;
   logic [31:0] addr_nxt, wdata_nxt;
   logic        arb_if, arb_d;

   always_comb begin
      state_nxt    = state;
      owner_d_nxt  = owner_d;
      wait_cnt_nxt = wait_cnt;
      starve_nxt   = starve_cnt;
      we_nxt       = 1'b0;
      addr_nxt     = mem_addr;
      wdata_nxt    = mem_wdata;
      arb_if       = 1'b0;
      arb_d        = 1'b0;
      case (state)
         IDLE, RESP: begin
            // Fetch wins when it has been starved long enough, or when data is absent.
            arb_if = if_req && ((starve_cnt == STARVE_LIM) || !d_req);
            arb_d  = d_req && !arb_if;
            if (arb_if) begin
               state_nxt   = ISSUE;
               owner_d_nxt = 1'b0;
               addr_nxt    = if_addr;
               starve_nxt  = 4'd0;
            end else if (arb_d) begin
               state_nxt   = ISSUE;
               owner_d_nxt = 1'b1;
               we_nxt      = d_we;
               addr_nxt    = d_addr;
               wdata_nxt   = d_wdata;
               if (!if_req)
                  starve_nxt = 4'd0;
               else if (starve_cnt != STARVE_LIM)
                  starve_nxt = starve_cnt + 4'd1;
            end else begin
               state_nxt  = IDLE;
               starve_nxt = 4'd0;
            end
         end
         ISSUE: begin
            // mem_we is the registered copy of the winner's write flag during ISSUE.
            wait_cnt_nxt = 3'd0;
            state_nxt    = mem_we ? IDLE : WAIT;
         end
         WAIT: begin
            if (wait_cnt == WAIT_LAST)
               state_nxt = RESP;
            else
               wait_cnt_nxt = wait_cnt + 3'd1;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // All outputs are registered from next-state values so they line up with the state they describe;
   // the asynchronous reset clears them at once, abandoning any transaction in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= IDLE;
         owner_d    <= 1'b0;
         wait_cnt   <= 3'd0;
         starve_cnt <= 4'd0;
         mem_en     <= 1'b0;
         mem_we     <= 1'b0;
         mem_addr   <= 32'd0;
         mem_wdata  <= 32'd0;
         if_gnt     <= 1'b0;
         d_gnt      <= 1'b0;
         if_rvalid  <= 1'b0;
         d_rvalid   <= 1'b0;
         if_rdata   <= 32'd0;
         d_rdata    <= 32'd0;
         busy       <= 1'b0;
      end else begin
         state      <= state_nxt;
         owner_d    <= owner_d_nxt;
         wait_cnt   <= wait_cnt_nxt;
         starve_cnt <= starve_nxt;
         mem_en     <= (state_nxt == ISSUE);
         mem_we     <= we_nxt;
         mem_addr   <= addr_nxt;
         mem_wdata  <= wdata_nxt;
         if_gnt     <= (state_nxt == ISSUE) && !owner_d_nxt;
         d_gnt      <= (state_nxt == ISSUE) && owner_d_nxt;
         busy       <= (state_nxt == ISSUE) || (state_nxt == WAIT);
         if_rvalid  <= (state_nxt == RESP) && !owner_d;
         d_rvalid   <= (state_nxt == RESP) && owner_d;
         // mem_rdata is valid in the last WAIT cycle; load it so it is visible during RESP.
         if ((state == WAIT) && (state_nxt == RESP)) begin
            if (owner_d)
               d_rdata <= mem_rdata;
            else
               if_rdata <= mem_rdata;
         end
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        if_req = 1'b0;
   logic [31:0] if_addr = '0;
   logic        d_req = 1'b0;
   logic        d_we = 1'b0;
   logic [31:0] d_addr = '0;
   logic [31:0] d_wdata = '0;

   // instance a: MEM_LAT=1, instance b: MEM_LAT=3; both STARVE_MAX=4 and share the request inputs
   logic        if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, busy_a;
   logic [31:0] if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a, mem_rdata_a;
   logic        if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, busy_b;
   logic [31:0] if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b, mem_rdata_b;
   logic [31:0] pipe_b0, pipe_b1;

   int checks = 0;
   int errors = 0;

   wire [134:0] all_out_a = {if_gnt_a, if_rvalid_a, d_gnt_a, d_rvalid_a, mem_en_a, mem_we_a, busy_a,
                             if_rdata_a, d_rdata_a, mem_addr_a, mem_wdata_a};
   wire [134:0] all_out_b = {if_gnt_b, if_rvalid_b, d_gnt_b, d_rvalid_b, mem_en_b, mem_we_b, busy_b,
                             if_rdata_b, d_rdata_b, mem_addr_b, mem_wdata_b};

   always #5 clk = ~clk;

   mem_port_arbiter #(.MEM_LAT(1), .STARVE_MAX(4)) dut_a (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_a), .if_rvalid(if_rvalid_a), .if_rdata(if_rdata_a),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_a), .d_rvalid(d_rvalid_a), .d_rdata(d_rdata_a),
      .mem_en(mem_en_a), .mem_we(mem_we_a), .mem_addr(mem_addr_a), .mem_wdata(mem_wdata_a),
      .mem_rdata(mem_rdata_a), .busy(busy_a));

   mem_port_arbiter #(.MEM_LAT(3), .STARVE_MAX(4)) dut_b (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt_b), .if_rvalid(if_rvalid_b), .if_rdata(if_rdata_b),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt_b), .d_rvalid(d_rvalid_b), .d_rdata(d_rdata_b),
      .mem_en(mem_en_b), .mem_we(mem_we_b), .mem_addr(mem_addr_b), .mem_wdata(mem_wdata_b),
      .mem_rdata(mem_rdata_b), .busy(busy_b));

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'd5) return 32'hCAFE0001;
      return 32'hA5A50000 ^ (a * 32'h01010101);
   endfunction

   // Memory models: data is valid exactly MEM_LAT cycles after the mem_en cycle, garbage otherwise.
   always @(posedge clk) begin
      mem_rdata_a <= mem_en_a ? mem_fn(mem_addr_a) : 32'hDEADBEEF;
      pipe_b0     <= mem_en_b ? mem_fn(mem_addr_b) : 32'hDEADBEEF;
      pipe_b1     <= pipe_b0;
      mem_rdata_b <= pipe_b1;
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
      if_addr = '0; d_addr = '0; d_wdata = '0;
      step(); step();
      rst_n = 1'b1;
      step();
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      step();
      checks++; if (all_out_a !== '0) begin errors++; $display("FAIL reset_outs_a: got %h expected 0", all_out_a); end
      checks++; if (all_out_b !== '0) begin errors++; $display("FAIL reset_outs_b: got %h expected 0", all_out_b); end
      do_reset();
      checks++; if (all_out_a !== '0) begin errors++; $display("FAIL idle_after_reset_a: got %h expected 0", all_out_a); end
   endtask

   task automatic test_fetch_read();
      do_reset();
      if_req = 1'b1; if_addr = 32'd5;                                   // cycle 0
      step();                                                           // cycle 1
      checks++; if (if_gnt_a !== 1'b1) begin errors++; $display("FAIL fr_if_gnt: got %b expected 1", if_gnt_a); end
      checks++; if ({mem_en_a, mem_we_a} !== 2'b10) begin errors++; $display("FAIL fr_en_we: got %b expected 10", {mem_en_a, mem_we_a}); end
      checks++; if (mem_addr_a !== 32'd5) begin errors++; $display("FAIL fr_addr: got %h expected 5", mem_addr_a); end
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL fr_busy1: got %b expected 1", busy_a); end
      checks++; if (d_gnt_a !== 1'b0) begin errors++; $display("FAIL fr_d_gnt: got %b expected 0", d_gnt_a); end
      if_req = 1'b0;
      step();                                                           // cycle 2
      checks++; if ({busy_a, mem_en_a, if_gnt_a, if_rvalid_a} !== 4'b1000) begin errors++; $display("FAIL fr_c2: got %b expected 1000", {busy_a, mem_en_a, if_gnt_a, if_rvalid_a}); end
      step();                                                           // cycle 3
      checks++; if (if_rvalid_a !== 1'b1) begin errors++; $display("FAIL fr_rvalid: got %b expected 1", if_rvalid_a); end
      checks++; if (if_rdata_a !== 32'hCAFE0001) begin errors++; $display("FAIL fr_rdata: got %h expected cafe0001", if_rdata_a); end
      checks++; if ({busy_a, d_rvalid_a} !== 2'b00) begin errors++; $display("FAIL fr_c3_busy: got %b expected 00", {busy_a, d_rvalid_a}); end
      step();                                                           // cycle 4
      checks++; if (if_rvalid_a !== 1'b0) begin errors++; $display("FAIL fr_rvalid_pulse: got %b expected 0", if_rvalid_a); end
      checks++; if (if_rdata_a !== 32'hCAFE0001) begin errors++; $display("FAIL fr_rdata_hold: got %h expected cafe0001", if_rdata_a); end
   endtask

   task automatic test_data_write();
      do_reset();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd9; d_wdata = 32'd7;       // cycle 0
      step();                                                           // cycle 1
      checks++; if ({mem_en_a, mem_we_a, d_gnt_a} !== 3'b111) begin errors++; $display("FAIL dw_en_we_gnt: got %b expected 111", {mem_en_a, mem_we_a, d_gnt_a}); end
      checks++; if (mem_addr_a !== 32'd9) begin errors++; $display("FAIL dw_addr: got %h expected 9", mem_addr_a); end
      checks++; if (mem_wdata_a !== 32'd7) begin errors++; $display("FAIL dw_wdata: got %h expected 7", mem_wdata_a); end
      d_addr = 32'd10; d_wdata = 32'd8;
      step();                                                           // cycle 2: IDLE
      checks++; if ({mem_en_a, busy_a, d_gnt_a} !== 3'b000) begin errors++; $display("FAIL dw_idle: got %b expected 000", {mem_en_a, busy_a, d_gnt_a}); end
      step();                                                           // cycle 3
      checks++; if ({mem_en_a, mem_we_a, d_gnt_a} !== 3'b111) begin errors++; $display("FAIL dw2_en_we_gnt: got %b expected 111", {mem_en_a, mem_we_a, d_gnt_a}); end
      checks++; if ({mem_addr_a, mem_wdata_a} !== {32'd10, 32'd8}) begin errors++; $display("FAIL dw2_addr_data: got %h expected 0000000a00000008", {mem_addr_a, mem_wdata_a}); end
      d_req = 1'b0;
      for (int c = 4; c < 9; c++) begin
         step();
         checks++; if ({d_rvalid_a, mem_en_a} !== 2'b00) begin errors++; $display("FAIL dw_no_rvalid c%0d: got %b expected 00", c, {d_rvalid_a, mem_en_a}); end
      end
   endtask

   task automatic test_simultaneous();
      do_reset();
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd3;                       // cycle 0
      step();                                                           // cycle 1
      checks++; if ({d_gnt_a, if_gnt_a} !== 2'b10) begin errors++; $display("FAIL sim_gnt1: got %b expected 10", {d_gnt_a, if_gnt_a}); end
      checks++; if (mem_addr_a !== 32'd3) begin errors++; $display("FAIL sim_addr1: got %h expected 3", mem_addr_a); end
      d_req = 1'b0;
      step();                                                           // cycle 2
      step();                                                           // cycle 3: RESP
      checks++; if ({d_rvalid_a, if_rvalid_a, if_gnt_a} !== 3'b100) begin errors++; $display("FAIL sim_resp: got %b expected 100", {d_rvalid_a, if_rvalid_a, if_gnt_a}); end
      checks++; if (d_rdata_a !== mem_fn(32'd3)) begin errors++; $display("FAIL sim_d_rdata: got %h expected %h", d_rdata_a, mem_fn(32'd3)); end
      step();                                                           // cycle 4
      checks++; if ({if_gnt_a, d_gnt_a, mem_en_a} !== 3'b101) begin errors++; $display("FAIL sim_if_gnt: got %b expected 101", {if_gnt_a, d_gnt_a, mem_en_a}); end
      checks++; if (mem_addr_a !== 32'd5) begin errors++; $display("FAIL sim_addr2: got %h expected 5", mem_addr_a); end
      if_req = 1'b0;
      step(); step();                                                   // cycle 6
      checks++; if ({if_rvalid_a, d_rvalid_a} !== 2'b10) begin errors++; $display("FAIL sim_if_rvalid: got %b expected 10", {if_rvalid_a, d_rvalid_a}); end
      checks++; if (if_rdata_a !== 32'hCAFE0001) begin errors++; $display("FAIL sim_if_rdata: got %h expected cafe0001", if_rdata_a); end
      checks++; if (d_rdata_a !== mem_fn(32'd3)) begin errors++; $display("FAIL sim_d_rdata_hold: got %h expected %h", d_rdata_a, mem_fn(32'd3)); end
   endtask

   task automatic test_starvation();
      int n = 0;
      do_reset();
      if_req = 1'b1; if_addr = 32'd5;
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'd2; d_wdata = 32'd1;
      for (int c = 1; c <= 40; c++) begin
         step();
         checks++; if (if_gnt_a && d_gnt_a) begin errors++; $display("FAIL starve_both_gnt c%0d: got 11 expected not both", c); end
         if (if_gnt_a || d_gnt_a) begin
            checks++;
            if (if_gnt_a !== (n % 5 == 4)) begin
               errors++; $display("FAIL starve_grant%0d: got if_gnt=%b expected %b", n, if_gnt_a, (n % 5 == 4));
            end
            n++;
         end
      end
      // D@1,3,5,7 I@9 D@12..18 I@20 D@23..29 I@31 D@34..40
      checks++; if (n != 19) begin errors++; $display("FAIL starve_grant_count: got %0d expected 19", n); end
      if_req = 1'b0; d_req = 1'b0;
   endtask

   task automatic test_latency_sweep();
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd1;                       // cycle 0
      for (int c = 1; c <= 12; c++) begin
         step();
         if (c == 1) begin
            checks++; if (d_gnt_b !== 1'b1) begin errors++; $display("FAIL lat_gnt1: got %b expected 1", d_gnt_b); end
            d_addr = 32'd2;
         end
         if (c == 6) begin
            checks++; if ({d_gnt_b, mem_en_b} !== 2'b11) begin errors++; $display("FAIL lat_gnt2: got %b expected 11", {d_gnt_b, mem_en_b}); end
            checks++; if (mem_addr_b !== 32'd2) begin errors++; $display("FAIL lat_addr2: got %h expected 2", mem_addr_b); end
            d_req = 1'b0;
         end
         checks++; if (d_rvalid_b !== (c == 5 || c == 10)) begin errors++; $display("FAIL lat_rvalid c%0d: got %b expected %b", c, d_rvalid_b, (c == 5 || c == 10)); end
         if (c == 5) begin
            checks++; if (d_rdata_b !== mem_fn(32'd1)) begin errors++; $display("FAIL lat_rdata1: got %h expected %h", d_rdata_b, mem_fn(32'd1)); end
         end
         if (c == 10) begin
            checks++; if (d_rdata_b !== mem_fn(32'd2)) begin errors++; $display("FAIL lat_rdata2: got %h expected %h", d_rdata_b, mem_fn(32'd2)); end
         end
      end
   endtask

   task automatic test_reset_mid_read();
      do_reset();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'd4;
      step(); d_req = 1'b0; step(); step();                           // cycle 3: RESP
      checks++; if (d_rdata_a !== mem_fn(32'd4)) begin errors++; $display("FAIL rst_pre_rdata: got %h expected %h", d_rdata_a, mem_fn(32'd4)); end
      step();
      d_req = 1'b1; d_addr = 32'd8;                                     // cycle 0
      step(); d_req = 1'b0;                                             // cycle 1
      step();                                                           // cycle 2: WAIT
      checks++; if (busy_a !== 1'b1) begin errors++; $display("FAIL rst_pre_busy: got %b expected 1", busy_a); end
      rst_n = 1'b0;
      #1;
      checks++; if ({busy_a, mem_en_a, d_rvalid_a} !== 3'b000) begin errors++; $display("FAIL rst_async: got %b expected 000", {busy_a, mem_en_a, d_rvalid_a}); end
      checks++; if (d_rdata_a !== 32'd0) begin errors++; $display("FAIL rst_rdata: got %h expected 0", d_rdata_a); end
      checks++; if (busy_b !== 1'b0) begin errors++; $display("FAIL rst_async_b: got %b expected 0", busy_b); end
      step(); step();
      rst_n = 1'b1;
      for (int c = 0; c < 5; c++) begin
         step();
         checks++; if (all_out_a !== '0) begin errors++; $display("FAIL rst_quiet c%0d: got %h expected 0", c, all_out_a); end
      end
      d_req = 1'b1; d_addr = 32'd6;                                     // cycle 0
      step();
      checks++; if ({d_gnt_a, mem_en_a} !== 2'b11) begin errors++; $display("FAIL rst_new_gnt: got %b expected 11", {d_gnt_a, mem_en_a}); end
      d_req = 1'b0;
      step(); step();                                                   // cycle 3
      checks++; if (d_rvalid_a !== 1'b1) begin errors++; $display("FAIL rst_new_rvalid: got %b expected 1", d_rvalid_a); end
      checks++; if (d_rdata_a !== mem_fn(32'd6)) begin errors++; $display("FAIL rst_new_rdata: got %h expected %h", d_rdata_a, mem_fn(32'd6)); end
   endtask

   initial begin
      test_reset();
      test_fetch_read();
      test_data_write();
      test_simultaneous();
      test_starvation();
      test_latency_sweep();
      test_reset_mid_read();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
